// File: rtl/dcfeb_ring_pkg.sv
// ============================================================================
// dcfeb_ring_pkg : shared ring-buffer defaults and L1A scheduler state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package dcfeb_ring_pkg;

  localparam int c_AW_DEF    = 12;
  localparam int c_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READY  = 2'b01,
    ST_BUSY   = 2'b10,
    ST_RETIRE = 2'b11
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/l1a_addr_fifo.sv
// ============================================================================
// l1a_addr_fifo : ring start-address queue, plain push/pop/occupancy storage
// Rev 1.0
// ============================================================================
`default_nettype none

module l1a_addr_fifo
  import dcfeb_ring_pkg::*;
#(
  parameter int AW    = c_AW_DEF,
  parameter int DEPTH = c_DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [AW-1:0]            i_din,
  output logic [AW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; entries are only read while the count covers them.
  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/l1a_addr_sched.sv
// ============================================================================
// l1a_addr_sched : queues pretrigger-corrected ring addresses per L1A and hands
// them to the transfer FSM. Optional macro L1A_MATCH_FILTER_EN: push only
// matched L1As. Rev 1.0
// ============================================================================
`default_nettype none

module l1a_addr_sched
  import dcfeb_ring_pkg::*;
#(
  parameter int AW    = c_AW_DEF,
  parameter int DEPTH = c_DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          L1A,
  input  logic          L1A_MATCH,
  input  logic [AW-1:0] RING_WADDR,
  input  logic [6:0]    PRE_SAMP,
  input  logic          LD_ADDR,
  input  logic          NXT_L1A,
  output logic [AW-1:0] START_ADDR,
  output logic          L1A_BUF_MT,
  output logic          L1A_BUF_FULL,
  output logic          OVFL,
  output logic          PROT_ERR,
  output logic [7:0]    DROP_CNT,
  output logic [1:0]    SCHED_STATE
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t  r_state;
  sched_state_t  w_state_nxt;
  logic [AW-1:0] w_push_addr;
  logic [AW-1:0] w_head;
  logic [AW-1:0] r_start_addr;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_cand;
  logic          w_pop;
  logic          w_drop;
  logic          w_push;
  logic          w_load;
  logic          w_prot;
  logic          r_ovfl;
  logic          r_prot_err;
  logic [7:0]    r_drop_cnt;

`ifdef L1A_MATCH_FILTER_EN
  assign w_cand = L1A & L1A_MATCH;
`else
  // Match qualifier is a don't-care in this build; OR-ing with 1 keeps the port referenced.
  assign w_cand = L1A & (L1A_MATCH | 1'b1);
`endif

  assign w_push_addr = RING_WADDR - AW'(PRE_SAMP);
  assign w_pop       = (r_state == ST_BUSY) & NXT_L1A;
  assign w_load      = (r_state == ST_READY) & LD_ADDR;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_drop      = w_cand & w_full & ~w_pop;
  assign w_push      = w_cand & ~w_drop;
  assign w_prot      = (LD_ADDR & (r_state != ST_READY)) | (NXT_L1A & (r_state != ST_BUSY));

  l1a_addr_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_addr),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_count != '0) w_state_nxt = ST_READY;
      ST_READY:  if (LD_ADDR)       w_state_nxt = ST_BUSY;
      ST_BUSY:   if (NXT_L1A)       w_state_nxt = ST_RETIRE;
      ST_RETIRE: w_state_nxt = (w_count != '0) ? ST_READY : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_start_addr <= '0;
      r_ovfl       <= 1'b0;
      r_prot_err   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_load) r_start_addr <= w_head;
      if (w_drop) r_ovfl <= 1'b1;
      if (w_prot) r_prot_err <= 1'b1;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign START_ADDR   = r_start_addr;
  assign L1A_BUF_MT   = w_empty;
  assign L1A_BUF_FULL = w_full;
  assign OVFL         = r_ovfl;
  assign PROT_ERR     = r_prot_err;
  assign DROP_CNT     = r_drop_cnt;
  assign SCHED_STATE  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_l1a_addr_sched.sv
// ============================================================================
// tb_l1a_addr_sched : directed bench for l1a_addr_sched with address scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_l1a_addr_sched;

  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          L1A = 1'b0;
  logic          L1A_MATCH = 1'b0;
  logic [AW-1:0] RING_WADDR = '0;
  logic [6:0]    PRE_SAMP = '0;
  logic          LD_ADDR = 1'b0;
  logic          NXT_L1A = 1'b0;
  logic [AW-1:0] START_ADDR;
  logic          L1A_BUF_MT;
  logic          L1A_BUF_FULL;
  logic          OVFL;
  logic          PROT_ERR;
  logic [7:0]    DROP_CNT;
  logic [1:0]    SCHED_STATE;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [AW-1:0] sb [$];
  int            mcount = 0;
  int            mdrop  = 0;

  l1a_addr_sched #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .L1A          (L1A),
    .L1A_MATCH    (L1A_MATCH),
    .RING_WADDR   (RING_WADDR),
    .PRE_SAMP     (PRE_SAMP),
    .LD_ADDR      (LD_ADDR),
    .NXT_L1A      (NXT_L1A),
    .START_ADDR   (START_ADDR),
    .L1A_BUF_MT   (L1A_BUF_MT),
    .L1A_BUF_FULL (L1A_BUF_FULL),
    .OVFL         (OVFL),
    .PROT_ERR     (PROT_ERR),
    .DROP_CNT     (DROP_CNT),
    .SCHED_STATE  (SCHED_STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [AW-1:0] a);
    if (mcount == DEPTH) begin
      if (mdrop < 255) mdrop++;
    end else begin
      sb.push_back(a);
      mcount++;
    end
  endtask

  task automatic send_l1a(input logic [AW-1:0] wa, input logic [6:0] ps, input logic m);
    logic [AW-1:0] a;
    a = wa - {5'b0, ps};
    RING_WADDR = wa;
    PRE_SAMP   = ps;
    L1A_MATCH  = m;
    L1A        = 1'b1;
    tick();
    L1A        = 1'b0;
    L1A_MATCH  = 1'b0;
`ifdef L1A_MATCH_FILTER_EN
    if (m) model_push(a);
`else
    model_push(a);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (SCHED_STATE !== 2'b01 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, SCHED_STATE, 2'b01);
  endtask

  task automatic serve();
    logic [AW-1:0] e;
    wait_ready("serve_ready");
    LD_ADDR = 1'b1;
    tick();
    LD_ADDR = 1'b0;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    chk("start_addr", START_ADDR, e);
    chk("serve_busy", SCHED_STATE, 2'b10);
    chk("mt_in_busy", L1A_BUF_MT, 1'b0);
    NXT_L1A = 1'b1;
    tick();
    NXT_L1A = 1'b0;
    mcount--;
    chk("serve_retire", SCHED_STATE, 2'b11);
    chk("mt_after_pop", L1A_BUF_MT, (mcount == 0));
    chk("start_hold", START_ADDR, e);
    tick();
    chk("after_retire", SCHED_STATE, (mcount > 0) ? 2'b01 : 2'b00);
  endtask

  task automatic sync_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
    mcount = 0;
    mdrop  = 0;
  endtask

  initial begin
    // Power-on reset state.
    tick();
    tick();
    chk("rst_state", SCHED_STATE, 2'b00);
    chk("rst_mt", L1A_BUF_MT, 1'b1);
    chk("rst_full", L1A_BUF_FULL, 1'b0);
    chk("rst_ovfl", OVFL, 1'b0);
    chk("rst_prot", PROT_ERR, 1'b0);
    chk("rst_drop", DROP_CNT, 8'd0);
    chk("rst_start", START_ADDR, 12'h000);
    RST = 1'b0;
    tick();

    // Single event with pretrigger wrap below zero.
    send_l1a(12'h005, 7'd10, 1'b1);
    chk("single_mt", L1A_BUF_MT, 1'b0);
    serve();
    chk("single_idle", SCHED_STATE, 2'b00);

    // Overfill: nine L1As, the last dropped.
    for (int i = 0; i < 9; i++) begin
      send_l1a((i == 0) ? 12'h003 : 12'(12'h100 + i * 17), (i == 0) ? 7'd100 : 7'(i * 9), 1'b1);
    end
    chk("fill_full", L1A_BUF_FULL, 1'b1);
    chk("fill_ovfl", OVFL, 1'b1);
    chk("fill_drop", DROP_CNT, 8'(mdrop));
    chk("fill_drop1", mdrop, 1);
    for (int i = 0; i < 8; i++) serve();
    chk("drain_idle", SCHED_STATE, 2'b00);
    chk("drain_mt", L1A_BUF_MT, 1'b1);
    chk("ovfl_sticky", OVFL, 1'b1);

    // Full queue, L1A coincident with the pop edge.
    sync_reset();
    chk("rst2_ovfl", OVFL, 1'b0);
    for (int i = 0; i < 8; i++) send_l1a(12'(12'h200 + i * 3), 7'd4, 1'b1);
    chk("full8", L1A_BUF_FULL, 1'b1);
    wait_ready("coin_ready");
    LD_ADDR = 1'b1;
    tick();
    LD_ADDR = 1'b0;
    chk("coin_start", START_ADDR, sb.pop_front());
    RING_WADDR = 12'h7A0;
    PRE_SAMP   = 7'h20;
    L1A        = 1'b1;
    NXT_L1A    = 1'b1;
    tick();
    L1A        = 1'b0;
    NXT_L1A    = 1'b0;
    sb.push_back(12'h780);
    chk("coin_full", L1A_BUF_FULL, 1'b1);
    chk("coin_ovfl", OVFL, 1'b0);
    chk("coin_drop", DROP_CNT, 8'd0);
    chk("coin_retire", SCHED_STATE, 2'b11);
    for (int i = 0; i < 8; i++) serve();
    chk("coin_idle", SCHED_STATE, 2'b00);

    // Handshake violations.
    LD_ADDR = 1'b1;
    tick();
    LD_ADDR = 1'b0;
    chk("prot_ld_state", SCHED_STATE, 2'b00);
    chk("prot_ld_flag", PROT_ERR, 1'b1);
    chk("prot_ld_mt", L1A_BUF_MT, 1'b1);
    send_l1a(12'h400, 7'd1, 1'b1);
    wait_ready("prot_ready");
    NXT_L1A = 1'b1;
    tick();
    NXT_L1A = 1'b0;
    chk("prot_nxt_state", SCHED_STATE, 2'b01);
    chk("prot_nxt_mt", L1A_BUF_MT, 1'b0);
    chk("prot_nxt_full", L1A_BUF_FULL, 1'b0);
    serve();
    chk("prot_sticky", PROT_ERR, 1'b1);

    // Asynchronous reset mid-event with three queued.
    for (int i = 0; i < 3; i++) send_l1a(12'(12'h050 + i), 7'd0, 1'b1);
    wait_ready("rst_busy_ready");
    LD_ADDR = 1'b1;
    tick();
    LD_ADDR = 1'b0;
    chk("rst_busy_pre", SCHED_STATE, 2'b10);
    RST = 1'b1;
    #2;
    chk("arst_state", SCHED_STATE, 2'b00);
    chk("arst_mt", L1A_BUF_MT, 1'b1);
    chk("arst_prot", PROT_ERR, 1'b0);
    chk("arst_ovfl", OVFL, 1'b0);
    chk("arst_drop", DROP_CNT, 8'd0);
    chk("arst_start", START_ADDR, 12'h000);
    tick();
    RST = 1'b0;
    sb.delete();
    mcount = 0;
    mdrop  = 0;
    NXT_L1A = 1'b1;
    tick();
    NXT_L1A = 1'b0;
    tick();
    chk("post_rst_idle", SCHED_STATE, 2'b00);
    chk("post_rst_mt", L1A_BUF_MT, 1'b1);

    // Match qualifier: 4 L1As, 2 matched.
    sync_reset();
    send_l1a(12'h600, 7'd2, 1'b1);
    send_l1a(12'h610, 7'd2, 1'b0);
    send_l1a(12'h620, 7'd2, 1'b1);
    send_l1a(12'h630, 7'd2, 1'b0);
    tick();
    chk("match_ovfl", OVFL, 1'b0);
    chk("match_drop", DROP_CNT, 8'd0);
    while (sb.size() > 0) serve();
    tick();
    chk("match_idle", SCHED_STATE, 2'b00);
    chk("match_mt", L1A_BUF_MT, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
